// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the PS/2 keyboard front end.
//   - Scan code set 2 constants for the bound keys and the prefix/BAT bytes.
//   - Receiver state enum used by ps2_rx.
//   - Key table (code + extended flag per held-flag slot) used by kbd_ctrl.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // E0-prefixed
  localparam logic [7:0] SC_RIGHT = 8'h74;  // E0-prefixed
  localparam logic [7:0] SC_UP    = 8'h75;  // E0-prefixed
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  // Held-flag slots: 0 A, 1 D, 2 W, 3 Space, 4 Left, 5 Right, 6 Up.
  localparam int NUM_KEYS = 7;
  localparam logic [NUM_KEYS*8-1:0] KEY_CODES =
    {SC_UP, SC_RIGHT, SC_LEFT, SC_SPACE, SC_W, SC_D, SC_A};
  localparam logic [NUM_KEYS-1:0] KEY_EXT = 7'b111_0000;

  // Odd parity over data plus parity bit holds when the total count of ones is odd.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/kbd_ctrl_ps2_rx.sv
// ps2_rx: PS/2 serial frame receiver.
//   clk, rst_n         : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data  : raw connector lines (asynchronous)
//   rx_byte            : last correctly received byte
//   rx_valid           : one-cycle pulse when rx_byte updates
//   frame_err          : one-cycle pulse on start/parity/stop/timeout error
// Both lines are double-synchronised; ps2_clk is glitch-filtered and its
// falling edge becomes a one-cycle sample strobe.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int CLK_HZ     = 65_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC) + 1;

  logic [1:0]            clk_sync_reg, data_sync_reg;
  logic [FILTER_LEN-1:0] hist_reg, hist_next;
  logic                  filt_reg, strobe_reg;

  ps2_state_t state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       parity_reg, parity_next;
  logic [7:0] byte_reg, byte_next;
  logic       valid_reg, valid_next;
  logic       err_reg, err_next;
  logic [TW-1:0] tmo_reg, tmo_next;

  logic data_s;
  assign data_s = data_sync_reg[1];

  // Sample history of the synchronised clock, newest in bit 0.
  assign hist_next[0] = clk_sync_reg[1];
  for (genvar gi = 1; gi < FILTER_LEN; gi++) begin : g_hist
    assign hist_next[gi] = hist_reg[gi-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      hist_reg      <= '1;
      filt_reg      <= 1'b1;
      strobe_reg    <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      hist_reg      <= hist_next;
      strobe_reg    <= 1'b0;
      // The filtered level only flips once FILTER_LEN equal samples agree.
      if (filt_reg && (hist_reg == '0)) begin
        filt_reg   <= 1'b0;
        strobe_reg <= 1'b1;
      end else if (!filt_reg && (&hist_reg)) begin
        filt_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      byte_reg    <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      tmo_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      byte_reg    <= byte_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
      tmo_reg     <= tmo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    byte_next    = byte_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    tmo_next     = '0;

    if (!strobe_reg && (state_reg != ST_IDLE)) begin
      tmo_next = tmo_reg + 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (strobe_reg) begin
          if (!data_s) begin
            state_next   = ST_DATA;
            bit_cnt_next = '0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (strobe_reg) begin
          shift_next = {data_s, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            state_next = ST_PARITY;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (strobe_reg) begin
          parity_next = data_s;
          state_next  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (strobe_reg) begin
          if (data_s && parity_ok(shift_reg, parity_reg)) begin
            byte_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A strobe this cycle already reloaded the counter, so the timeout cannot
    // collide with a frame completion.
    if (!strobe_reg && (state_reg != ST_IDLE) && (tmo_reg == TW'(TIMEOUT_CYC - 1))) begin
      state_next = ST_IDLE;
      err_next   = 1'b1;
      tmo_next   = '0;
    end
  end

  assign rx_byte   = byte_reg;
  assign rx_valid  = valid_reg;
  assign frame_err = err_reg;

endmodule

// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 keyboard front end producing held-key movement levels.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data   : raw PS/2 connector lines
//   stepleft            : A or Left held
//   stepright           : D or Right held
//   stepjump            : W, Space or Up held
//   rx_byte/rx_valid    : last good byte and its update pulse
//   frame_err           : receive error pulse
// Decodes scan code set 2 make/break sequences (E0 / F0 prefixes) into one
// held flag per bound key; 0xAA (self-test pass after hot-plug) drops all keys.
module kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int CLK_HZ     = 65_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       stepleft,
  output logic       stepright,
  output logic       stepjump,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  ps2_rx #(
    .CLK_HZ    (CLK_HZ),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  logic ext_reg, ext_next;
  logic brk_reg, brk_next;
  logic clr_all, key_ev;
  logic [NUM_KEYS-1:0] match, held_reg, held_next;
  logic left_reg, right_reg, jump_reg;

  always_comb begin
    ext_next = ext_reg;
    brk_next = brk_reg;
    clr_all  = 1'b0;
    key_ev   = 1'b0;
    if (frame_err) begin
      ext_next = 1'b0;
      brk_next = 1'b0;
    end else if (rx_valid) begin
      case (rx_byte)
        SC_EXT: ext_next = 1'b1;
        SC_BRK: brk_next = 1'b1;
        SC_BAT: begin
          ext_next = 1'b0;
          brk_next = 1'b0;
          clr_all  = 1'b1;
        end
        default: begin
          // Any key code, bound or not, ends the prefix sequence.
          ext_next = 1'b0;
          brk_next = 1'b0;
          key_ev   = 1'b1;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    assign match[gi] = (rx_byte == KEY_CODES[gi*8 +: 8]) && (ext_reg == KEY_EXT[gi]);
    assign held_next[gi] = clr_all ? 1'b0 :
                           (key_ev && match[gi]) ? !brk_reg : held_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_reg   <= 1'b0;
      brk_reg   <= 1'b0;
      held_reg  <= '0;
      left_reg  <= 1'b0;
      right_reg <= 1'b0;
      jump_reg  <= 1'b0;
    end else begin
      ext_reg   <= ext_next;
      brk_reg   <= brk_next;
      held_reg  <= held_next;
      // Registered from the next-state flags so the outputs move on the
      // cycle right after rx_valid.
      left_reg  <= held_next[0] | held_next[4];
      right_reg <= held_next[1] | held_next[5];
      jump_reg  <= held_next[2] | held_next[3] | held_next[6];
    end
  end

  assign stepleft  = left_reg;
  assign stepright = right_reg;
  assign stepjump  = jump_reg;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Testbench for kbd_ctrl: table-driven frames plus hand-written sequences
// for strobe latency, glitch rejection, timeout and reset mid-frame.
// Runs with a 1 MHz nominal clock and a 300 us timeout (300 cycles).
module tb_kbd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       stepleft, stepright, stepjump;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_err;

  always #5 clk = ~clk;

  kbd_ctrl #(
    .CLK_HZ    (1_000_000),
    .FILTER_LEN(8),
    .TIMEOUT_US(300)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .stepleft (stepleft),
    .stepright(stepright),
    .stepjump (stepjump),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (rx_valid) n_valid++;
    if (frame_err) n_err++;
    if (rx_valid && frame_err) begin
      checks++;
      errors++;
      $display("FAIL valid_err_overlap: rx_valid=1 frame_err=1 at %0t, required not both", $time);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Sends the first nbits of an 11-bit frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] fr;
    logic par;
    par = ~(^b);
    if (bad) par = ~par;
    fr = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      cyc(10);
      ps2_clk = 1'b0;
      cyc(20);
      ps2_clk = 1'b1;
      cyc(10);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    send_bits(b, bad, 11);
    cyc(4);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [7:0] exp_rx;
    bit         l;
    bit         r;
    bit         j;
    int         dv;
    int         de;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    int v0, e0;

    vecs = '{
      '{8'h1C, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b0, 1, 0},  // make A
      '{8'hF0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1, 0},
      '{8'h1C, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0, 1, 0},  // break A
      '{8'hE0, 1'b0, 8'hE0, 1'b0, 1'b0, 1'b0, 1, 0},
      '{8'h74, 1'b0, 8'h74, 1'b0, 1'b1, 1'b0, 1, 0},  // make Right
      '{8'h23, 1'b0, 8'h23, 1'b0, 1'b1, 1'b0, 1, 0},  // make D
      '{8'hF0, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b0, 1, 0},
      '{8'h23, 1'b0, 8'h23, 1'b0, 1'b1, 1'b0, 1, 0},  // break D, Right still held
      '{8'hE0, 1'b0, 8'hE0, 1'b0, 1'b1, 1'b0, 1, 0},
      '{8'hF0, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b0, 1, 0},
      '{8'h74, 1'b0, 8'h74, 1'b0, 1'b0, 1'b0, 1, 0},  // break Right
      '{8'h29, 1'b1, 8'h74, 1'b0, 1'b0, 1'b0, 0, 1},  // Space, bad parity
      '{8'h29, 1'b0, 8'h29, 1'b0, 1'b0, 1'b1, 1, 0},  // make Space
      '{8'hF0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1, 0},
      '{8'h29, 1'b0, 8'h29, 1'b0, 1'b0, 1'b0, 1, 0},  // break Space
      '{8'h1C, 1'b0, 8'h1C, 1'b1, 1'b0, 1'b0, 1, 0},  // make A
      '{8'hE0, 1'b0, 8'hE0, 1'b1, 1'b0, 1'b0, 1, 0},
      '{8'h75, 1'b0, 8'h75, 1'b1, 1'b0, 1'b1, 1, 0},  // make Up
      '{8'hAA, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1, 0},  // BAT clears all
      '{8'hE0, 1'b0, 8'hE0, 1'b0, 1'b0, 1'b0, 1, 0},
      '{8'h74, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 0, 1},  // error drops the E0 prefix
      '{8'h74, 1'b0, 8'h74, 1'b0, 1'b0, 1'b0, 1, 0}   // plain 0x74 is unbound
    };

    // Reset state
    cyc(5);
    chk("reset_stepleft", stepleft, 0);
    chk("reset_stepright", stepright, 0);
    chk("reset_stepjump", stepjump, 0);
    chk("reset_rx_byte", rx_byte, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    rst_n = 1'b1;
    cyc(20);

    // Table-driven frames
    for (int i = 0; i < NV; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[i].code, vecs[i].bad);
      chk($sformatf("v%0d_rx_byte", i), rx_byte, vecs[i].exp_rx);
      chk($sformatf("v%0d_stepleft", i), stepleft, vecs[i].l);
      chk($sformatf("v%0d_stepright", i), stepright, vecs[i].r);
      chk($sformatf("v%0d_stepjump", i), stepjump, vecs[i].j);
      chk($sformatf("v%0d_valid_cnt", i), n_valid - v0, vecs[i].dv);
      chk($sformatf("v%0d_err_cnt", i), n_err - e0, vecs[i].de);
      $display("vec %0d: code=%02h bad=%0d rx=%02h L=%0d R=%0d J=%0d", i, vecs[i].code,
               vecs[i].bad, rx_byte, stepleft, stepright, stepjump);
    end

    // Latency: rx_valid 12 cycles and stepright 13 cycles after the stop-bit falling edge
    send_bits(8'h23, 1'b0, 10);
    ps2_data = 1'b1;
    cyc(10);
    ps2_clk = 1'b0;
    cyc(12);
    chk("lat_rx_valid_at12", rx_valid, 1);
    chk("lat_stepright_at12", stepright, 0);
    cyc(1);
    chk("lat_rx_valid_at13", rx_valid, 0);
    chk("lat_stepright_at13", stepright, 1);
    cyc(19);
    ps2_clk = 1'b1;
    cyc(10);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h23, 1'b0);
    chk("lat_break_d", stepright, 0);
    $display("latency seq: make/break D done");

    // Glitches shorter than the filter produce no strobe
    v0 = n_valid;
    e0 = n_err;
    ps2_clk = 1'b0;
    cyc(5);
    ps2_clk = 1'b1;
    cyc(30);
    ps2_clk = 1'b0;
    cyc(7);
    ps2_clk = 1'b1;
    cyc(30);
    chk("glitch_no_valid", n_valid - v0, 0);
    chk("glitch_no_err", n_err - e0, 0);
    send_frame(8'h1C, 1'b0);
    chk("glitch_then_make_a", stepleft, 1);
    chk("glitch_then_rx", rx_byte, 8'h1C);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("glitch_break_a", stepleft, 0);
    $display("glitch seq: errs=%0d valids=%0d", n_err - e0, n_valid - v0);

    // Timeout after a partial frame (start + 4 data bits)
    v0 = n_valid;
    e0 = n_err;
    send_bits(8'h1D, 1'b0, 5);
    cyc(270);
    chk("tmo_not_early", n_err - e0, 0);
    cyc(30);
    chk("tmo_err", n_err - e0, 1);
    chk("tmo_no_valid", n_valid - v0, 0);
    send_frame(8'h1D, 1'b0);
    chk("tmo_next_rx", rx_byte, 8'h1D);
    chk("tmo_next_jump", stepjump, 1);
    chk("tmo_next_no_err", n_err - e0, 1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    chk("tmo_break_w", stepjump, 0);
    $display("timeout seq: errs=%0d", n_err - e0);

    // Reset mid-frame
    send_frame(8'h1C, 1'b0);
    chk("rst_pre_left", stepleft, 1);
    send_bits(8'h23, 1'b0, 4);
    rst_n = 1'b0;
    cyc(2);
    chk("rst_stepleft", stepleft, 0);
    chk("rst_rx_byte", rx_byte, 0);
    rst_n = 1'b1;
    cyc(5);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h23, 1'b0);
    chk("rst_after_rx", rx_byte, 8'h23);
    chk("rst_after_right", stepright, 1);
    chk("rst_after_left", stepleft, 0);
    chk("rst_after_valid", n_valid - v0, 1);
    chk("rst_after_err", n_err - e0, 0);
    $display("reset seq: rx=%02h R=%0d L=%0d", rx_byte, stepright, stepleft);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbd_ctrl.md
# kbd_ctrl

PS/2 keyboard front end that produces the held-key movement levels consumed by the character controller (`stepleft`, `stepright`, `stepjump`). It receives serial PS/2 frames from the board connector, validates them and decodes scan code set 2 make/break sequences. It keeps one held flag per bound key. It runs in the 65 MHz pixel clock domain alongside the game logic.

## Interface

**Parameters**
- `CLK_HZ`, 65_000_000: system clock frequency, used to derive the timeout.
- `FILTER_LEN`, 8: number of consecutive equal samples of `ps2_clk` required to accept a level change.
- `TIMEOUT_US`, 2000: idle time after which a partial frame is discarded.

**Ports**
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ps2_clk`, in, 1: PS/2 clock from the connector; asynchronous; open-collector, idle high.
- `ps2_data`, in, 1: PS/2 data from the connector; asynchronous.
- `stepleft`, out, 1: high while A or Left-arrow is held.
- `stepright`, out, 1: high while D or Right-arrow is held.
- `stepjump`, out, 1: high while W, Space or Up-arrow is held.
- `rx_byte`, out, 8: last correctly received byte.
- `rx_valid`, out, 1: one-cycle pulse when `rx_byte` updates.
- `frame_err`, out, 1: one-cycle pulse on a parity, start-bit, stop-bit or timeout error.

## Operation

**Input conditioning**
- `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
- `ps2_clk` then passes through a `FILTER_LEN` glitch filter.
- A falling edge of the filtered clock is the sample strobe.

**Receiver FSM** (states IDLE, DATA, PARITY, STOP)
- IDLE: on a strobe, data=0 moves to DATA with bit_cnt=0. Data=1 is a start error: pulse `frame_err` and stay in IDLE.
- DATA: shift data in LSB first. After the 8th bit, move to PARITY.
- PARITY: capture the parity bit, move to STOP.
- STOP: the frame is good only if stop=1 and odd parity holds over the 8 data bits plus the parity bit. A good frame loads `rx_byte` and pulses `rx_valid`. A bad frame pulses `frame_err` and leaves `rx_byte` unchanged. Both cases return to IDLE.
- Timeout: a counter reloads on every strobe. If no strobe arrives for `TIMEOUT_US` while not in IDLE, pulse `frame_err` and return to IDLE. The terminal count is CLK_HZ/1_000_000*TIMEOUT_US, held in an 18-bit counter at the defaults.

**Decoder**, acting on each `rx_valid`
- 0xE0 sets the `ext` flag.
- 0xF0 sets the `brk` flag.
- Any other byte is a key code, looked up with `ext`:
  - Non-extended: 0x1C A, 0x23 D, 0x1D W, 0x29 Space.
  - Extended: 0x6B Left, 0x74 Right, 0x75 Up.
  - A matching key's held flag is set to !brk.
  - `ext` and `brk` are then cleared. Unbound codes only clear the flags.
- 0xAA (keyboard self-test pass, i.e. hot-plug) clears all held flags and both prefix flags.
- `frame_err` clears `ext` and `brk`; held flags are kept.

**Outputs**
- `stepleft` = A | Left. `stepright` = D | Right. `stepjump` = W | Space | Up.
- All three are registered. Simultaneous left and right are both asserted; priority is the consumer's decision.
- Typematic repeats of a make code are idempotent.

## Timing

- Reset values: all outputs 0, FSM in IDLE, all prefix and held flags 0.
- A reset asserted mid-frame discards the partial byte immediately. The next falling edge with data=1 produces a start error, which is expected after reset.
- Strobe latency: a `ps2_clk` falling edge produces the strobe 2 + `FILTER_LEN` + 1 cycles later (11 cycles at defaults). The strobe is one cycle wide.
- `rx_valid` asserts on the cycle after the stop-bit strobe.
- Step outputs change on the cycle after `rx_valid`, i.e. 2 cycles after the stop-bit strobe.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no strobe.
- `rx_valid` and `frame_err` are never asserted in the same cycle.

## Structure

- New package `kbd_pkg` holds:
  - the scan code constants (`SC_A`, `SC_D`, `SC_W`, `SC_SPACE`, `SC_LEFT`, `SC_RIGHT`, `SC_UP`, `SC_EXT`, `SC_BRK`, `SC_BAT`);
  - the receiver state enum `ps2_state_t`.
- Sub-module `ps2_rx` contains the synchronizers, filter, receiver FSM and timeout. Its outputs are `rx_byte`, `rx_valid` and `frame_err`.
- `kbd_ctrl` instantiates `ps2_rx` and contains the prefix/held-flag decoder.

## Test plan

- **Make A, then break A:** frames 0x1C, then 0xF0 and 0x1C → `stepleft` rises 2 cycles after the first stop strobe and falls after the second 0x1C. `rx_byte` sequence is 1C, F0, 1C.
- **Extended Right held while D is pressed and released:** E0 74, 23, F0 23 → `stepright` stays high throughout. Then E0 F0 74 → `stepright` low.
- **Bad parity:** frame 0x29 sent with even parity → `frame_err` pulses once, no `rx_valid`, `stepjump` stays 0. A following good 0x29 sets `stepjump`.
- **Timeout:** 4 bits sent, then idle for 2.1 ms → `frame_err` pulses and the FSM is in IDLE. The next full frame 0x1D is received correctly.
- **Glitch and BAT:** a 5-cycle low pulse on `ps2_clk` → no strobe and no state change. With A and Up held, frame 0xAA → all step outputs go to 0.
- **Reset mid-frame:** `rst_n` pulsed low after 3 data bits → all outputs 0. A full frame after release decodes correctly.
